// File: rtl/dmem_responder.sv
// dmem_responder: in-order data-memory responder with a fixed number of wait states per request.
// Accepts one word request at a time; responds with a one-cycle strobe after LATENCY edges.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d, err_q, err_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          accept, go, wr_en;
    logic [31:0]   mem_q [DEPTH];

    assign req_ready = state_q != BUSY;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // The *_d capture values are the live transaction on the edge entering RESP,
    // whether it was just accepted (LATENCY=1) or has been waiting in BUSY.
    always_comb begin
        accept  = req_valid && req_ready;
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        go      = 1'b0;
        if (accept) begin
            we_d    = req_we;
            err_d   = (|req_addr[1:0]) || (|req_addr[ADDR_W-1:IW+2]);
            idx_d   = req_addr[IW+1:2];
            wdata_d = req_wdata;
            state_d = LATENCY == 1 ? RESP : BUSY;
            cnt_d   = CNT_INIT;
            go      = LATENCY == 1;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q - 4'(cnt_q != 4'd0);
            state_d = cnt_q == 4'd0 ? RESP : BUSY;
            go      = cnt_q == 4'd0;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
        wr_en       = go && we_d && !err_d;
        rsp_valid_d = go;
        rsp_err_d   = go && err_d;
        rsp_rdata_d = (go && !we_d && !err_d) ? mem_q[idx_d] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Array is never reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && rst) mem_q[idx_d] <= wdata_d;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at LATENCY 1, 2 and 7 sharing one request bus.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        r1, r2, r7, v1, v2, v7, e1, e2, e7;
    logic [31:0] d1, d2, d7;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(1), .ADDR_W(32)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1));
    dmem_responder #(.DEPTH(256), .LATENCY(2), .ADDR_W(32)) u2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r2), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v2), .rsp_rdata(d2), .rsp_err(e2));
    dmem_responder #(.DEPTH(256), .LATENCY(7), .ADDR_W(32)) u7 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(r7), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(v7), .rsp_rdata(d7), .rsp_err(e7));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request on the LATENCY=2 responder; returns in its RESP cycle.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e);
        chk({tag, "_rdy0"}, r2, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_AAAA;
        chk({tag, "_busy"}, r2, 0);
        chk({tag, "_nov"}, v2, 0);
        tick();
        chk({tag, "_v"}, v2, 1);
        chk({tag, "_d"}, d2, exp_d);
        chk({tag, "_e"}, e2, exp_e);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int lat1, lat2, lat7, nr1, nr2, nr7, nv1, nv2, nv7;
        logic [31:0] sd1, sd2, sd7;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h1;
        tick();
        tick();
        chk("rst_rdy", r2, 1);
        chk("rst_v", v2, 0);
        chk("rst_d", d2, 0);
        chk("rst_e", e2, 0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_noacc", r2, 1);
        chk("rst_noacc_v", v2, 0);

        xact("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'd0, 1'b0);
        tick();
        chk("st10_back_v", v2, 0);
        xact("ld10", 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("ld10_clr_d", d2, 0);

        xact("st20", 1'b1, 32'h20, 32'h1234_5678, 32'd0, 1'b0);
        xact("ld20", 1'b0, 32'h20, 32'd0, 32'h1234_5678, 1'b0);

        xact("ld13", 1'b0, 32'h13, 32'd0, 32'd0, 1'b1);
        xact("st00", 1'b1, 32'h0, 32'hA5A5_A5A5, 32'd0, 1'b0);
        xact("st400", 1'b1, 32'h400, 32'hFFFF_0000, 32'd0, 1'b1);
        xact("ld00", 1'b0, 32'h0, 32'd0, 32'hA5A5_A5A5, 1'b0);
        xact("ld400", 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
        tick();
        chk("err_clr_e", e2, 0);

        xact("st08a", 1'b1, 32'h08, 32'h1111_1111, 32'd0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h08;
        req_wdata = 32'hCAFE_F00D;
        tick();
        req_valid = 1'b0;
        chk("mid_busy", r2, 0);
        rst = 1'b0;
        #1;
        chk("mid_rst_rdy", r2, 1);
        tick();
        chk("mid_rst_v", v2, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rel_rdy", r2, 1);
        tick();
        chk("mid_rel_v", v2, 0);
        chk("mid_rel_rdy2", r2, 1);
        xact("ld08", 1'b0, 32'h08, 32'd0, 32'h1111_1111, 1'b0);

        idle(10);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h04;
        req_wdata = 32'h0BAD_CAFE;
        tick();
        idle(10);
        lat1 = 0; lat2 = 0; lat7 = 0;
        nr1 = 0; nr2 = 0; nr7 = 0;
        nv1 = 0; nv2 = 0; nv7 = 0;
        sd1 = 0; sd2 = 0; sd7 = 0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h04;
        for (int k = 0; k < 12; k++) begin
            tick();
            req_valid = 1'b0;
            if (!r1) nr1++;
            if (!r2) nr2++;
            if (!r7) nr7++;
            if (v1) begin nv1++; if (lat1 == 0) lat1 = k + 1; sd1 = d1; end
            if (v2) begin nv2++; if (lat2 == 0) lat2 = k + 1; sd2 = d2; end
            if (v7) begin nv7++; if (lat7 == 0) lat7 = k + 1; sd7 = d7; end
        end
        chk("sw1_lat", lat1, 1);
        chk("sw2_lat", lat2, 2);
        chk("sw7_lat", lat7, 7);
        chk("sw1_rdy", nr1, 0);
        chk("sw2_rdy", nr2, 1);
        chk("sw7_rdy", nr7, 6);
        chk("sw1_nv", nv1, 1);
        chk("sw2_nv", nv2, 1);
        chk("sw7_nv", nv7, 1);
        chk("sw1_d", sd1, 32'h0BAD_CAFE);
        chk("sw2_d", sd2, 32'h0BAD_CAFE);
        chk("sw7_d", sd7, 32'h0BAD_CAFE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
